// File: rtl/kuznechik_pkg.sv
// Shared Kuznechik (GOST R 34.12-2015) definitions: FSM states, round keys,
// pi S-box with its derived inverse, and the GF(2^8) arithmetic used by the linear layer.
package kuznechik_pkg;

  localparam int NUM_KEYS = 10;
  localparam int BLOCK_W  = 128;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [0:255][7:0]  byte_tbl_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_LINV,
    ST_SINV,
    ST_FINISH
  } state_e;

  // Round keys K0..K9 expanded from master key 8899aabb..0123456789abcdef.
  localparam block_t KEYS [NUM_KEYS] = '{
    128'h8899aabbccddeeff0011223344556677,
    128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  // Coefficients of l() in argument order a14, a13, ..., a0, a15 (the R^-1 order).
  localparam logic [7:0] L_COEF [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  localparam byte_tbl_t PI = '{
    8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
    8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
    8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
    8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
    8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
    8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
    8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
    8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
    8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
  };

  function automatic byte_tbl_t invert_tbl(input byte_tbl_t t);
    byte_tbl_t r;
    r = '0;
    for (int i = 0; i < 256; i++) r[t[i]] = 8'(i);
    return r;
  endfunction

  localparam byte_tbl_t PI_INV = invert_tbl(PI);

  // Multiply modulo x^8+x^7+x^6+x+1; with a constant operand this folds to an XOR net.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic block_t sub_inv(input block_t b);
    block_t r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = PI_INV[b[i*8 +: 8]];
    return r;
  endfunction

endpackage

// File: rtl/kuznechik_decipher_if.sv
// Request/valid/ack/busy handshake bundle shared by the Kuznechik encryptor and decryptor.
interface kuznechik_decipher_if;
  import kuznechik_pkg::*;

  logic   request_i;
  logic   ack_i;
  block_t data_i;
  logic   busy_o;
  logic   valid_o;
  block_t data_o;

  modport slave  (input request_i, ack_i, data_i, output busy_o, valid_o, data_o);
  modport master (output request_i, ack_i, data_i, input busy_o, valid_o, data_o);
endinterface

// File: rtl/kuznechik_decipher_r_inv_step.sv
// One inverse linear-feedback step R^-1: shift the block up a byte and append l() of the rotated block.
module kuznechik_r_inv_step
  import kuznechik_pkg::*;
(
  input  block_t data_i,
  output block_t data_o
);

  block_t     rot;
  logic [7:0] fb;

  // rot presents the l() arguments a14..a0, a15 from the most significant byte down.
  assign rot = {data_i[119:0], data_i[127:120]};

  always_comb begin
    fb = '0;
    for (int i = 0; i < 16; i++) fb = fb ^ gf_mul(L_COEF[i], rot[127-8*i -: 8]);
  end

  assign data_o = {data_i[119:0], fb};

endmodule

// File: rtl/kuznechik_decipher.sv
// Iterative Kuznechik block decryptor: K9 whitening, then nine rounds of L^-1, S^-1, key XOR.
// Define KUZNECHIK_DECIPHER_FULL_L_EN to unroll L^-1 into a single cycle (3-cycle rounds).
module kuznechik_decipher
  import kuznechik_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  kuznechik_decipher_if.slave  bus
);

  state_e     state_q, state_d;
  block_t     work_q, work_d;
  block_t     out_q, out_d;
  logic [3:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  block_t     keyed;
  block_t     linv;

`ifdef KUZNECHIK_DECIPHER_FULL_L_EN
  block_t chain [17];
  assign chain[0] = work_q;
  for (genvar g = 0; g < 16; g++) begin : g_r_inv
    kuznechik_r_inv_step u_step (.data_i(chain[g]), .data_o(chain[g+1]));
  end
  assign linv = chain[16];
`else
  logic [3:0] cnt_q, cnt_d;
  kuznechik_r_inv_step u_step (.data_i(work_q), .data_o(linv));
`endif

  assign keyed = work_q ^ KEYS[idx_q];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifndef KUZNECHIK_DECIPHER_FULL_L_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.request_i) begin
          work_d  = bus.data_i;
          idx_d   = 4'd9;
          state_d = ST_KEY;
        end
      end
      ST_KEY: begin
        work_d = keyed;
        if (idx_q == 4'd0) begin
          out_d   = keyed;
          valid_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q - 4'd1;
`ifndef KUZNECHIK_DECIPHER_FULL_L_EN
          cnt_d   = '0;
`endif
          state_d = ST_LINV;
        end
      end
      ST_LINV: begin
        work_d = linv;
`ifdef KUZNECHIK_DECIPHER_FULL_L_EN
        state_d = ST_SINV;
`else
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_SINV;
`endif
      end
      ST_SINV: begin
        work_d  = sub_inv(work_q);
        state_d = ST_KEY;
      end
      ST_FINISH: begin
        // A new request wins over ack; both end the hold of the current result.
        if (bus.request_i) begin
          work_d  = bus.data_i;
          idx_d   = 4'd9;
          valid_d = 1'b0;
          state_d = ST_KEY;
        end else if (bus.ack_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifndef KUZNECHIK_DECIPHER_FULL_L_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifndef KUZNECHIK_DECIPHER_FULL_L_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.busy_o  = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign bus.valid_o = valid_q;
  assign bus.data_o  = out_q;

endmodule

// File: tb/tb_kuznechik_decipher.sv
// Scoreboard bench for kuznechik_decipher: a forward-cipher reference model produces ciphertexts,
// the expected plaintexts are queued, and a monitor checks each result as valid_o rises.
module tb_kuznechik_decipher;
  import kuznechik_pkg::*;

`ifdef KUZNECHIK_DECIPHER_FULL_L_EN
  localparam int LAT = 28;
`else
  localparam int LAT = 163;
`endif
  localparam int BUSY_EDGE = (LAT > 60) ? 50 : 10;
  localparam int RST_EDGE  = (LAT > 100) ? 80 : 15;

  localparam block_t GOST_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam block_t GOST_PT = 128'h1122334455667700ffeeddccbbaa9988;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  block_t sb [$];
  logic prev_valid = 1'b0;

  kuznechik_decipher_if bus ();

  kuznechik_decipher dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h1C3 << (i - 8));
    return p[7:0];
  endfunction

  // l(a15..a0) with the standard coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1.
  function automatic logic [7:0] m_lin(input block_t x);
    int c [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};
    logic [7:0] s;
    s = '0;
    for (int j = 0; j < 16; j++) s = s ^ m_mul(8'(c[j]), x[8*(15-j) +: 8]);
    return s;
  endfunction

  function automatic block_t m_l(input block_t x);
    block_t d = x;
    for (int i = 0; i < 16; i++) d = {m_lin(d), d[127:8]};
    return d;
  endfunction

  function automatic block_t m_l_inv(input block_t x);
    block_t d = x;
    for (int i = 0; i < 16; i++) d = {d[119:0], m_lin({d[119:0], d[127:120]})};
    return d;
  endfunction

  function automatic block_t m_s(input block_t x);
    block_t d;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = PI[x[8*i +: 8]];
    return d;
  endfunction

  function automatic block_t m_s_inv(input block_t x);
    block_t d = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 256; j++)
        if (PI[j] == x[8*i +: 8]) d[8*i +: 8] = 8'(j);
    return d;
  endfunction

  function automatic block_t m_encrypt(input block_t pt);
    block_t d = pt;
    for (int i = 0; i < 9; i++) d = m_l(m_s(d ^ KEYS[i]));
    return d ^ KEYS[9];
  endfunction

  function automatic block_t m_decrypt(input block_t ct);
    block_t d = ct ^ KEYS[9];
    for (int r = 8; r >= 0; r--) d = m_s_inv(m_l_inv(d)) ^ KEYS[r];
    return d;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.valid_o === 1'b1 && !prev_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", 128'(bus.valid_o), 128'(0));
        end else begin
          check("data_o", bus.data_o, sb.pop_front());
        end
      end
      prev_valid = (bus.valid_o === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_req(input block_t din);
    @(negedge clk);
    bus.data_i    = din;
    bus.request_i = 1'b1;
    @(posedge clk);
    #1;
    bus.request_i = 1'b0;
    bus.data_i    = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_valid(input string name, input int n0);
    int n    = n0;
    bit seen = 1'b0;
    while (!seen && n < LAT + 20) begin
      @(posedge clk);
      n++;
      #1;
      if (n == LAT - 1) check({name, "_busy"}, 128'(bus.busy_o), 128'(1));
      if (bus.valid_o === 1'b1) seen = 1'b1;
    end
    check({name, "_latency"}, 128'(n), 128'(LAT));
  endtask

  task automatic run_block(input string name, input block_t ct, input block_t pt);
    sb.push_back(pt);
    start_req(ct);
    wait_valid(name, 0);
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.ack_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ack_i = 1'b0;
    check("ack_valid_low", 128'(bus.valid_o), 128'(0));
    check("ack_busy_low", 128'(bus.busy_o), 128'(0));
  endtask

  initial begin
    block_t pt, ct, nxt;
    bus.request_i = 1'b0;
    bus.ack_i     = 1'b0;
    bus.data_i    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 128'(bus.valid_o), 128'(0));
    check("rst_data", bus.data_o, 128'(0));
    check("rst_busy", 128'(bus.busy_o), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // GOST test vector, then hold the result without ack
    run_block("gost", GOST_CT, GOST_PT);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", 128'(bus.valid_o), 128'(1));
      check("hold_data", bus.data_o, GOST_PT);
    end
    do_ack();

    // Request while busy is ignored
    sb.push_back(GOST_PT);
    start_req(GOST_CT);
    repeat (BUSY_EDGE - 1) @(posedge clk);
    @(negedge clk);
    bus.request_i = 1'b1;
    bus.data_i    = ~GOST_CT;
    @(posedge clk);
    #1;
    bus.request_i = 1'b0;
    check("busy_req_busy", 128'(bus.busy_o), 128'(1));
    wait_valid("busy_req", BUSY_EDGE);

    // Request and ack together in FINISH: request wins
    pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    nxt = m_encrypt(pt);
    sb.push_back(pt);
    @(negedge clk);
    bus.data_i    = nxt;
    bus.request_i = 1'b1;
    bus.ack_i     = 1'b1;
    @(posedge clk);
    #1;
    bus.request_i = 1'b0;
    bus.ack_i     = 1'b0;
    check("req_ack_valid", 128'(bus.valid_o), 128'(0));
    check("req_ack_busy", 128'(bus.busy_o), 128'(1));
    wait_valid("req_ack", 0);
    do_ack();

    // Asynchronous reset mid-operation
    start_req(GOST_CT);
    repeat (RST_EDGE) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(bus.valid_o), 128'(0));
    check("mid_rst_data", bus.data_o, 128'(0));
    check("mid_rst_busy", 128'(bus.busy_o), 128'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run_block("gost_after_rst", GOST_CT, GOST_PT);
    do_ack();

    // All-zero ciphertext and X check
    run_block("zero_ct", 128'(0), m_decrypt(128'(0)));
    check("no_x", 128'($isunknown({bus.valid_o, bus.busy_o, bus.data_o})), 128'(0));

    // Random round trips, mixing ack-then-request with back-to-back requests
    for (int i = 0; i < 100; i++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct = m_encrypt(pt);
      if ($urandom_range(1) == 1) do_ack();
      run_block("round_trip", ct, pt);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
